alarm_buzzer_ctrl: RTL and testbench

//  Consumer end of the alarm ring line: turns the level ring from the alarm

---
 rtl/alarm_buzzer_ctrl.sv | 152 +++++++++++++++
 tb/tb_alarm_buzzer_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: turns the alarm ring level into a beeping buzzer
// drive, with snooze/dismiss handling, an unanswered-alert timeout and re-fire blocking.
module alarm_buzzer_ctrl #(
  parameter int TONE_DIV          = 25000,
  parameter int BEAT_DIV          = 50000000,
  parameter int SNOOZE_MIN        = 5,
  parameter int ALERT_TIMEOUT_MIN = 3,
  parameter int MAX_SNOOZE        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ring,
  input  logic min_tick,
  input  logic btn_snooze,
  input  logic btn_dismiss,
  output logic buzzer,
  output logic alerting,
  output logic snoozing
);

  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int AM_W   = (ALERT_TIMEOUT_MIN > 1) ? $clog2(ALERT_TIMEOUT_MIN) : 1;
  // These two counters must hold their parameter value itself, hence the +1.
  localparam int SL_W   = $clog2(SNOOZE_MIN + 1);
  localparam int SU_W   = $clog2(MAX_SNOOZE + 1);

  localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEAT_DIV - 1);
  localparam logic [AM_W-1:0]   AM_LAST    = AM_W'(ALERT_TIMEOUT_MIN - 1);
  localparam logic [SL_W-1:0]   SL_INIT    = SL_W'(SNOOZE_MIN);
  localparam logic [SL_W-1:0]   SL_ONE     = SL_W'(1);
  localparam logic [SU_W-1:0]   SU_MAX     = SU_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    SNOOZE   = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_ring_d;
  logic                r_buzzer;
  logic                r_beat_on;
  logic                r_tone;
  logic [TONE_W-1:0]   r_tone_cnt;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [AM_W-1:0]     r_alert_min;
  logic [SL_W-1:0]     r_snooze_left;
  logic [SU_W-1:0]     r_snooze_used;

  logic w_trig;
  logic w_timeout;
  logic w_snooze_done;
  logic w_enter_alert;
  logic w_alert_hold;

  assign w_trig        = ring & ~r_ring_d;
  assign w_timeout     = min_tick & (r_alert_min == AM_LAST);
  assign w_snooze_done = min_tick & (r_snooze_left == SL_ONE);

  assign w_enter_alert = ((r_state == IDLE) & w_trig) |
                         ((r_state == SNOOZE) & ~btn_dismiss & w_snooze_done);

  // Any snooze press leaves ALERT (to SNOOZE or, when exhausted, to WAIT_CLR),
  // so the buzzer is silenced in the same cycle the state changes.
  assign w_alert_hold  = (r_state == ALERT) & ~btn_dismiss & ~btn_snooze & ~w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      // NOTE: ring_d resets high so a ring already in progress is not seen as a fresh rising edge.
      r_ring_d      <= 1'b1;
      r_buzzer      <= 1'b0;
      r_beat_on     <= 1'b0;
      r_tone        <= 1'b0;
      r_tone_cnt    <= '0;
      r_beat_cnt    <= '0;
      r_alert_min   <= '0;
      r_snooze_left <= '0;
      r_snooze_used <= '0;
    end else begin
      r_ring_d <= ring;
      r_buzzer <= w_alert_hold & r_beat_on & r_tone;

      unique case (r_state)
        IDLE: begin
          if (w_trig) r_state <= ALERT;
        end
        ALERT: begin
          if (btn_dismiss) begin
            r_state <= WAIT_CLR;
          end else if (btn_snooze && (r_snooze_used == SU_MAX)) begin
            r_state <= WAIT_CLR;
          end else if (btn_snooze) begin
            r_state       <= SNOOZE;
            r_snooze_left <= SL_INIT;
            r_snooze_used <= r_snooze_used + 1'b1;
          end else if (w_timeout) begin
            r_state <= WAIT_CLR;
          end else if (min_tick) begin
            r_alert_min <= r_alert_min + 1'b1;
          end
        end
        SNOOZE: begin
          if (btn_dismiss) begin
            r_state <= WAIT_CLR;
          end else if (w_snooze_done) begin
            r_state <= ALERT;
          end else if (min_tick) begin
            r_snooze_left <= r_snooze_left - 1'b1;
          end
        end
        WAIT_CLR: begin
          if (!ring) begin
            r_state       <= IDLE;
            r_snooze_used <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Every entry into ALERT restarts the tone/beat pattern and the timeout.
      if (w_enter_alert) begin
        r_beat_on   <= 1'b1;
        r_tone      <= 1'b1;
        r_tone_cnt  <= '0;
        r_beat_cnt  <= '0;
        r_alert_min <= '0;
      end else if (r_state == ALERT) begin
        if (r_tone_cnt == TONE_LAST) begin
          r_tone_cnt <= '0;
          r_tone     <= ~r_tone;
        end else begin
          r_tone_cnt <= r_tone_cnt + 1'b1;
        end
        if (r_beat_cnt == BEAT_LAST) begin
          r_beat_cnt <= '0;
          r_beat_on  <= ~r_beat_on;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign buzzer   = r_buzzer;
  assign alerting = (r_state == ALERT);
  assign snoozing = (r_state == SNOOZE);

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Directed bench for alarm_buzzer_ctrl with small parameters; outputs are
// sampled 1 ns after each rising edge, inputs driven at the same point.
module tb_alarm_buzzer_ctrl;

  logic clk = 1'b0;
  logic rst, ring, min_tick, btn_snooze, btn_dismiss;
  logic buzzer, alerting, snoozing;

  int n_total = 0;
  int n_bad   = 0;

  alarm_buzzer_ctrl #(
    .TONE_DIV(2), .BEAT_DIV(8), .SNOOZE_MIN(2), .ALERT_TIMEOUT_MIN(3), .MAX_SNOOZE(2)
  ) dut (
    .clk(clk), .rst(rst), .ring(ring), .min_tick(min_tick),
    .btn_snooze(btn_snooze), .btn_dismiss(btn_dismiss),
    .buzzer(buzzer), .alerting(alerting), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    min_tick = 1'b1; cyc(); min_tick = 1'b0;
  endtask

  task automatic pulse_snooze();
    btn_snooze = 1'b1; cyc(); btn_snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    btn_dismiss = 1'b1; cyc(); btn_dismiss = 1'b0;
  endtask

  initial begin
    logic exp_b;
    rst = 1'b1; ring = 1'b0; min_tick = 1'b0; btn_snooze = 1'b0; btn_dismiss = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_alerting", alerting, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    check("rst_buzzer", buzzer, 1'b0);
    cyc(5);
    check("idle_quiet", alerting, 1'b0);

    // Rising ring: alerting one edge later, buzzer one edge after that.
    ring = 1'b1;
    cyc();
    check("trig_alerting", alerting, 1'b1);
    check("trig_buzzer_lag", buzzer, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      exp_b = (((k - 1) % 4) < 2) && (((k - 1) % 16) < 8);
      check($sformatf("beep_k%0d", k), buzzer, exp_b);
    end
    check("still_alerting", alerting, 1'b1);

    // First snooze, ignored extra snooze, 2-minute expiry.
    pulse_snooze();
    check("snz1_snoozing", snoozing, 1'b1);
    check("snz1_alerting", alerting, 1'b0);
    check("snz1_buzzer", buzzer, 1'b0);
    cyc(3);
    pulse_tick();
    check("snz1_tick1", snoozing, 1'b1);
    pulse_snooze();
    check("snz1_btn_ignored", snoozing, 1'b1);
    cyc(2);
    pulse_tick();
    check("snz1_realert", alerting, 1'b1);
    cyc();
    check("snz1_realert_buzz", buzzer, 1'b1);

    // Second snooze, then the third press acts as dismiss.
    pulse_snooze();
    check("snz2_snoozing", snoozing, 1'b1);
    pulse_tick();
    pulse_tick();
    check("snz2_realert", alerting, 1'b1);
    pulse_snooze();
    check("snz3_alerting", alerting, 1'b0);
    check("snz3_snoozing", snoozing, 1'b0);
    cyc(4);
    check("waitclr_no_refire", alerting, 1'b0);
    ring = 1'b0; cyc();
    ring = 1'b1; cyc();
    check("rearm_alert", alerting, 1'b1);

    // Snooze budget was cleared on IDLE; dismiss from SNOOZE.
    pulse_snooze();
    check("budget_cleared", snoozing, 1'b1);
    pulse_dismiss();
    check("snz_dismiss_snoozing", snoozing, 1'b0);
    check("snz_dismiss_alerting", alerting, 1'b0);
    ring = 1'b0; cyc();
    ring = 1'b1; cyc();
    check("alert_again", alerting, 1'b1);

    // Both buttons together: dismiss wins.
    btn_snooze = 1'b1; btn_dismiss = 1'b1; cyc();
    btn_snooze = 1'b0; btn_dismiss = 1'b0;
    check("both_alerting", alerting, 1'b0);
    check("both_snoozing", snoozing, 1'b0);
    cyc(2);
    check("both_snoozing_later", snoozing, 1'b0);

    // Timeout after 3 unanswered minutes; ring falling does not stop the alert.
    ring = 1'b0; cyc();
    ring = 1'b1; cyc();
    check("to_alert", alerting, 1'b1);
    pulse_tick();
    cyc(2);
    pulse_tick();
    check("to_tick2_alerting", alerting, 1'b1);
    pulse_tick();
    check("to_tick3_stopped", alerting, 1'b0);
    cyc();
    check("to_buzzer_off", buzzer, 1'b0);
    cyc(4);
    check("to_no_refire", alerting, 1'b0);
    ring = 1'b0; cyc();
    ring = 1'b1; cyc();
    check("to_rearm", alerting, 1'b1);
    ring = 1'b0; cyc(3);
    check("ring_fall_keeps_alert", alerting, 1'b1);

    // Reset while ringing in ALERT: no re-trigger until ring cycles.
    ring = 1'b1; cyc(3);
    check("pre_rst_buzzer", buzzer, 1'b1);
    rst = 1'b1; cyc();
    rst = 1'b0;
    check("rst_alert_off", alerting, 1'b0);
    check("rst_buzzer_off", buzzer, 1'b0);
    cyc(5);
    check("rst_no_retrigger", alerting, 1'b0);
    ring = 1'b0; cyc();
    ring = 1'b1; cyc();
    check("rst_rearm", alerting, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
